// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous data RAM between the Hack CPU
// and one secondary device, with bounded CPU priority and locked device bursts.
`default_nettype none

module ram_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 16,
  parameter int CPU_BURST = 4,
  parameter int DEV_MAX   = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_wr_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_din_i,
  output logic          cpu_stall_o,
  output logic [DW-1:0] cpu_dout_o,
  output logic          cpu_rvalid_o,
  input  logic          dev_req_i,
  input  logic          dev_lock_i,
  input  logic          dev_wr_i,
  input  logic [AW-1:0] dev_addr_i,
  input  logic [DW-1:0] dev_din_i,
  output logic          dev_gnt_o,
  output logic [DW-1:0] dev_dout_o,
  output logic          dev_rvalid_o,
  output logic          ram_wr_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  localparam int SW = $clog2(CPU_BURST + 1);
  localparam int BW = $clog2(DEV_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_BURST);
  localparam logic [BW-1:0] BEATS_MAX  = BW'(DEV_MAX);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CPU      = 2'd1;
  localparam logic [1:0] S_DEV      = 2'd2;
  localparam logic [1:0] S_DEV_LOCK = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] cpu_streak_q, cpu_streak_d;
  logic [BW-1:0] dev_beats_q, dev_beats_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_dev_q, rd_dev_d;
  logic          cpu_gnt, dev_gnt;
  logic          any_gnt;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;

  // Grants are forced off while reset is held so nothing reaches the RAM.
  always_comb begin
    cpu_gnt = 1'b0;
    dev_gnt = 1'b0;
    if (rst_ni) begin
      if (state_q == S_DEV_LOCK && dev_req_i && dev_beats_q < BEATS_MAX) begin
        dev_gnt = 1'b1;
      end else if (cpu_req_i && !dev_req_i) begin
        cpu_gnt = 1'b1;
      end else if (dev_req_i && !cpu_req_i) begin
        dev_gnt = 1'b1;
      end else if (cpu_req_i && dev_req_i) begin
        if (cpu_streak_q < STREAK_MAX) cpu_gnt = 1'b1;
        else                           dev_gnt = 1'b1;
      end
    end
  end

  assign any_gnt  = cpu_gnt | dev_gnt;
  assign sel_wr   = dev_gnt ? dev_wr_i : cpu_wr_i;
  assign sel_addr = dev_gnt ? dev_addr_i : cpu_addr_i;

  always_comb begin
    cpu_streak_d = cpu_streak_q;
    if (dev_gnt || !dev_req_i) begin
      cpu_streak_d = '0;
    end else if (cpu_gnt && cpu_streak_q < STREAK_MAX) begin
      cpu_streak_d = cpu_streak_q + 1'b1;
    end

    dev_beats_d = '0;
    if (dev_gnt) begin
      dev_beats_d = (dev_beats_q < BEATS_MAX) ? dev_beats_q + 1'b1 : dev_beats_q;
    end

    // An exhausted lock hands the port to a waiting CPU before it can relock.
    state_d = S_IDLE;
    if (dev_gnt) begin
      if (dev_lock_i && dev_beats_d == BEATS_MAX) state_d = cpu_req_i ? S_CPU : S_DEV;
      else if (dev_lock_i)                        state_d = S_DEV_LOCK;
      else                                        state_d = S_DEV;
    end else if (cpu_gnt) begin
      state_d = S_CPU;
    end

    addr_d     = any_gnt ? sel_addr : addr_q;
    rd_valid_d = any_gnt & ~sel_wr;
    rd_dev_d   = dev_gnt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cpu_streak_q <= '0;
      dev_beats_q  <= '0;
      addr_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_dev_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_streak_q <= cpu_streak_d;
      dev_beats_q  <= dev_beats_d;
      addr_q       <= addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_dev_q     <= rd_dev_d;
    end
  end

  assign cpu_stall_o  = cpu_req_i & ~cpu_gnt;
  assign dev_gnt_o    = dev_gnt;
  assign ram_wr_o     = any_gnt & sel_wr;
  assign ram_addr_o   = any_gnt ? sel_addr : addr_q;
  assign ram_din_o    = dev_gnt ? dev_din_i : cpu_din_i;
  assign cpu_dout_o   = ram_dout_i;
  assign dev_dout_o   = ram_dout_i;
  assign cpu_rvalid_o = rd_valid_q & ~rd_dev_q;
  assign dev_rvalid_o = rd_valid_q & rd_dev_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a queue-based read-data scoreboard.
`default_nettype none

module tb_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_dout;
  logic          dev_req = 1'b0, dev_lock = 1'b0, dev_wr = 1'b0;
  logic [AW-1:0] dev_addr = '0;
  logic [DW-1:0] dev_din = '0;
  logic          dev_gnt, dev_rvalid;
  logic [DW-1:0] dev_dout;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dev_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .CPU_BURST(4), .DEV_MAX(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_stall_o(cpu_stall), .cpu_dout_o(cpu_dout), .cpu_rvalid_o(cpu_rvalid),
    .dev_req_i(dev_req), .dev_lock_i(dev_lock), .dev_wr_i(dev_wr), .dev_addr_i(dev_addr),
    .dev_din_i(dev_din), .dev_gnt_o(dev_gnt), .dev_dout_o(dev_dout), .dev_rvalid_o(dev_rvalid),
    .ram_wr_o(ram_wr), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  // Synchronous single-port RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected read data whenever an rvalid is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_rvalid && dev_rvalid) chk("rvalid_exclusive", 1, 0);
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
        else chk("cpu_dout", {16'h0, cpu_dout}, {16'h0, cpu_q.pop_front()});
      end
      if (dev_rvalid) begin
        if (dev_q.size() == 0) chk("dev_rvalid_unexpected", 1, 0);
        else chk("dev_dout", {16'h0, dev_dout}, {16'h0, dev_q.pop_front()});
      end
    end
  end

  // One cycle: drive at posedge+1, check grants at negedge, queue expected reads.
  task automatic cyc(input logic creq, input logic cwr, input int caddr, input int cdin,
                     input logic dreq, input logic dlock, input logic dwr, input int daddr,
                     input int ddin, input logic exp_cg, input logic exp_dg,
                     input int exp_cd, input int exp_dd, input string name);
    cpu_req = creq; cpu_wr = cwr; cpu_addr = AW'(caddr); cpu_din = DW'(cdin);
    dev_req = dreq; dev_lock = dlock; dev_wr = dwr; dev_addr = AW'(daddr); dev_din = DW'(ddin);
    @(negedge clk);
    chk({name, "_stall"}, cpu_stall, creq & ~exp_cg);
    chk({name, "_dev_gnt"}, dev_gnt, exp_dg);
    if (exp_cg && !cwr) cpu_q.push_back(DW'(exp_cd));
    if (exp_dg && !dwr) dev_q.push_back(DW'(exp_dd));
    @(posedge clk); #1;
  endtask

  task automatic idle(input string name);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, name);
  endtask

  initial begin
    mem[1] = 16'd7;     mem[2] = 16'd9;     mem[5] = 16'd100;
    mem[10] = 16'h1010; mem[11] = 16'h1111; mem[200] = 16'h0000;

    // Reset state with both requesters asserting.
    cpu_req = 1; dev_req = 1;
    #2;
    chk("rst_stall", cpu_stall, 1);
    chk("rst_dev_gnt", dev_gnt, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rvalid", {cpu_rvalid, dev_rvalid}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle("idle0");

    // CPU-only read.
    cyc(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 100, 0, "cpu_only");
    idle("cpu_only_after");

    // Contention: C,C,C,C,D repeating.
    for (int i = 0; i < 12; i++) begin
      logic d;
      d = (i % 5) == 4;
      cyc(1, 0, 10, 0, 1, 0, 0, 11, 0, !d, d, 16'h1010, 16'h1111, "contend");
    end
    idle("contend_after");

    // Locked burst: 8 device beats, one CPU grant, then the lock resumes.
    cyc(0, 0, 5, 0, 1, 1, 0, 11, 0, 0, 1, 0, 16'h1111, "lock0");
    for (int i = 1; i < 8; i++) cyc(1, 0, 5, 0, 1, 1, 0, 11, 0, 0, 1, 0, 16'h1111, "lock_dev");
    cyc(1, 0, 5, 0, 1, 1, 0, 11, 0, 1, 0, 100, 0, "lock_cpu");
    cyc(0, 0, 5, 0, 1, 1, 0, 11, 0, 0, 1, 0, 16'h1111, "lock_resume");
    cyc(1, 0, 5, 0, 1, 1, 0, 11, 0, 0, 1, 0, 16'h1111, "relock1");
    cyc(1, 0, 5, 0, 1, 1, 0, 11, 0, 0, 1, 0, 16'h1111, "relock2");
    cyc(1, 0, 5, 0, 0, 0, 0, 11, 0, 1, 0, 100, 0, "lock_end");
    idle("lock_after");

    // Device write then CPU read of the same address.
    cyc(0, 0, 0, 0, 1, 0, 1, 200, 16'hBEEF, 0, 1, 0, 0, "dev_write");
    chk("wr_seen", 1, 1 - 1 + 1);
    cyc(1, 0, 200, 0, 0, 0, 0, 0, 0, 1, 0, 16'hBEEF, 0, "cpu_rd200");
    idle("wr_after");

    // Interleaved reads.
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, "inter_cpu");
    cyc(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 0, 9, "inter_dev");
    idle("inter_after1");
    idle("inter_after2");

    // Reset right after a granted CPU read: its data must never return.
    cpu_req = 1; cpu_wr = 0; cpu_addr = 15'd5; dev_req = 0;
    @(negedge clk);
    chk("pre_rst_stall", cpu_stall, 0);
    @(posedge clk); #1;
    rst_n = 0; dev_req = 1;
    #1;
    chk("mid_rst_rvalid", cpu_rvalid, 0);
    chk("mid_rst_stall", cpu_stall, 1);
    chk("mid_rst_dev_gnt", dev_gnt, 0);
    chk("mid_rst_ram_wr", ram_wr, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      logic d;
      d = (i == 4);
      cyc(1, 0, 10, 0, 1, 0, 0, 11, 0, !d, d, 16'h1010, 16'h1111, "post_rst");
    end
    idle("end1");
    idle("end2");

    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dev_q_drained", dev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
